// File: rtl/pin_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pin_bank_arbiter                                                           |
// | Round-robin ownership arbiter for a shared pad bank with bus turnaround.   |
// | Optional grant timeout: define PIN_BANK_ARB_TIMEOUT_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pin_bank_arbiter #(
  parameter int NumReq        = 2,
  parameter int Width         = 8,
  parameter int TurnCycles    = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  output logic [NumReq-1:0]       gnt_o,
  input  logic [NumReq*Width-1:0] req_o_i,
  input  logic [NumReq*Width-1:0] req_oe_i,
  input  logic [NumReq*Width-1:0] req_pu_i,
  input  logic [NumReq*Width-1:0] req_pd_i,
  output logic [Width-1:0]        pins_o,
  output logic [Width-1:0]        pins_oe_o,
  output logic [Width-1:0]        pins_pu_o,
  output logic [Width-1:0]        pins_pd_o,
  input  logic [Width-1:0]        pins_i,
  output logic [Width-1:0]        sample_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int c_IDX_W = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    OWNED = 2'd2
  } state_t;

  if (NumReq < 2 || NumReq > 8 || TurnCycles < 1 || TurnCycles > 15 || TimeoutCycles < 1)
  begin : g_bad_params
    $error("pin_bank_arbiter: parameter out of range");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_turn_cnt;
  logic [3:0]           w_turn_nxt;
  logic [c_IDX_W-1:0]   r_last;
  logic [c_IDX_W-1:0]   r_owner;
  logic [c_IDX_W-1:0]   w_pick;
  logic                 w_found;
  logic [NumReq-1:0]    w_req_eff;
  logic [NumReq-1:0]    w_owner_oh;
  logic                 w_tmo_hit;
  logic [Width-1:0]     r_sample;

  logic [Width-1:0] w_o  [NumReq];
  logic [Width-1:0] w_oe [NumReq];
  logic [Width-1:0] w_pu [NumReq];
  logic [Width-1:0] w_pd [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign w_o[g]  = req_o_i [g*Width +: Width];
    assign w_oe[g] = req_oe_i[g*Width +: Width];
    assign w_pu[g] = req_pu_i[g*Width +: Width];
    assign w_pd[g] = req_pd_i[g*Width +: Width];
  end

  assign w_owner_oh = {{(NumReq-1){1'b0}}, 1'b1} << r_owner;

  // Round-robin search begins one past the most recent requester that was granted.
  always_comb begin
    logic [c_IDX_W-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= NumReq; k++) begin
      idx = c_IDX_W'((int'(r_last) + k) % NumReq);
      if (!w_found && w_req_eff[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_turn_nxt  = r_turn_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = TURN;
          w_turn_nxt  = 4'(TurnCycles - 1);
        end
      end
      TURN: begin
        if (!req_i[r_owner]) begin
          w_state_nxt = IDLE;
        end else if (r_turn_cnt == 4'd0) begin
          w_state_nxt = OWNED;
        end else begin
          w_turn_nxt = r_turn_cnt - 4'd1;
        end
      end
      OWNED: begin
        if (!req_i[r_owner] || w_tmo_hit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_turn_cnt <= '0;
      r_last     <= c_IDX_W'(NumReq - 1);
      r_owner    <= '0;
      r_sample   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_sample   <= pins_i;
      if (r_state == IDLE && w_found) begin
        r_owner <= w_pick;
      end
      // Aborted turnarounds leave the pointer alone so the same requester is not skipped.
      if (r_state == TURN && w_state_nxt == OWNED) begin
        r_last <= r_owner;
      end
    end
  end

`ifdef PIN_BANK_ARB_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TimeoutCycles + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [NumReq-1:0]  r_mask;
  logic               r_timeout;
  logic               w_force;

  assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TimeoutCycles - 1));
  assign w_force   = (r_state == OWNED) && req_i[r_owner] && w_tmo_hit;
  assign w_req_eff = req_i & ~r_mask;
  assign timeout_o = r_timeout;

  // A masked requester is released as soon as its request is sampled low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo_cnt <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      r_tmo_cnt <= (r_state == OWNED) ? r_tmo_cnt + 1'b1 : '0;
      r_mask    <= (r_mask & req_i) | (w_force ? w_owner_oh : '0);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign w_req_eff = req_i;
  assign timeout_o = 1'b0;
`endif

  // Pull-up wins over pull-down on every bit so the pad never sees both.
  always_comb begin
    gnt_o     = '0;
    pins_o    = '0;
    pins_oe_o = '0;
    pins_pu_o = '0;
    pins_pd_o = '0;
    case (r_state)
      TURN: begin
        pins_pu_o = w_pu[r_owner];
        pins_pd_o = w_pd[r_owner] & ~w_pu[r_owner];
      end
      OWNED: begin
        gnt_o     = w_owner_oh;
        pins_o    = w_o[r_owner];
        pins_oe_o = w_oe[r_owner];
        pins_pu_o = w_pu[r_owner];
        pins_pd_o = w_pd[r_owner] & ~w_pu[r_owner];
      end
      default: ;
    endcase
  end

  assign busy_o   = (r_state != IDLE);
  assign sample_o = r_sample;

endmodule
`default_nettype wire

// File: tb/tb_pin_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pin_bank_arbiter                                                        |
// | Scoreboard bench: per-cycle expectations queued by the driver, checked     |
// | by a negedge monitor. Timeout scenario runs with PIN_BANK_ARB_TIMEOUT_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pin_bank_arbiter;

  localparam int NR     = 2;
  localparam int W      = 8;
  localparam int K_IDLE = 0;
  localparam int K_TURN = 1;
  localparam int K_OWN  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NR-1:0]   req, gnt;
  logic [NR*W-1:0] d_o, d_oe, d_pu, d_pd;
  logic [W-1:0]    p_o, p_oe, p_pu, p_pd, p_i, smp;
  logic            busy, tmo;

  pin_bank_arbiter #(
    .NumReq(NR), .Width(W), .TurnCycles(2), .TimeoutCycles(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
    .req_o_i(d_o), .req_oe_i(d_oe), .req_pu_i(d_pu), .req_pd_i(d_pd),
    .pins_o(p_o), .pins_oe_o(p_oe), .pins_pu_o(p_pu), .pins_pd_o(p_pd),
    .pins_i(p_i), .sample_o(smp), .busy_o(busy), .timeout_o(tmo)
  );

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic          busy;
    logic [W-1:0]  o, oe, pu, pd, smp;
    logic          tmo;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  m_e;
  string m_tag;

  logic [W-1:0] m_o[NR], m_oe[NR], m_pu[NR], m_pd[NR];
  logic [W-1:0] exp_smp;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      check_val({m_tag, "/gnt"},    32'(gnt),  32'(m_e.gnt));
      check_val({m_tag, "/busy"},   32'(busy), 32'(m_e.busy));
      check_val({m_tag, "/pins"},   32'(p_o),  32'(m_e.o));
      check_val({m_tag, "/oe"},     32'(p_oe), 32'(m_e.oe));
      check_val({m_tag, "/pu"},     32'(p_pu), 32'(m_e.pu));
      check_val({m_tag, "/pd"},     32'(p_pd), 32'(m_e.pd));
      check_val({m_tag, "/sample"}, 32'(smp),  32'(m_e.smp));
      check_val({m_tag, "/tmo"},    32'(tmo),  32'(m_e.tmo));
    end
  end

  // pd_out is the pull-down the pads should see once pull-up priority applies.
  task automatic set_drive(input int r, input logic [W-1:0] o, oe, pu, pd, pd_out);
    d_o [r*W +: W] = o;
    d_oe[r*W +: W] = oe;
    d_pu[r*W +: W] = pu;
    d_pd[r*W +: W] = pd;
    m_o[r] = o; m_oe[r] = oe; m_pu[r] = pu; m_pd[r] = pd_out;
  endtask

  task automatic cyc(input string tag, input int kind, input int r, input logic t = 1'b0);
    exp_t e;
    e     = '0;
    e.smp = exp_smp;
    e.tmo = t;
    if (kind == K_TURN) begin
      e.busy = 1'b1; e.pu = m_pu[r]; e.pd = m_pd[r];
    end else if (kind == K_OWN) begin
      e.busy = 1'b1; e.gnt = NR'(1) << r;
      e.o = m_o[r]; e.oe = m_oe[r]; e.pu = m_pu[r]; e.pd = m_pd[r];
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    p_i = W'($urandom);
    @(posedge clk); #1;
    exp_smp = rst ? '0 : p_i;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    exp_smp = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; p_i = '0; exp_smp = '0;
    d_o = '0; d_oe = '0; d_pu = '0; d_pd = '0;
    set_drive(0, 8'hA5, 8'hFF, 8'h0F, 8'hF0, 8'hF0);
    set_drive(1, 8'h3C, 8'h0F, 8'h33, 8'h55, 8'h44);
    @(posedge clk); #1;
    do_reset();
    cyc("reset", K_IDLE, 0);

    // single requester: TURN in cycles 1-2, grant from cycle 3
    req = 2'b01;
    cyc("t1_c0", K_IDLE, 0);
    cyc("t1_c1", K_TURN, 0);
    cyc("t1_c2", K_TURN, 0);
    cyc("t1_c3", K_OWN, 0);
    cyc("t1_c4", K_OWN, 0);
    req = 2'b00;
    cyc("t1_rel", K_OWN, 0);
    cyc("t1_idle", K_IDLE, 0);

    // owner 1 aborts in TURN; pointer stays at 0 so the next tie goes to 1
    req = 2'b10;
    cyc("t3_c0", K_IDLE, 0);
    req = 2'b00;
    cyc("t3_turn", K_TURN, 1);
    cyc("t3_abort", K_IDLE, 0);
    req = 2'b11;
    cyc("t3_tie", K_IDLE, 0);
    cyc("t3_tu1", K_TURN, 1);
    cyc("t3_tu2", K_TURN, 1);
    cyc("t3_own", K_OWN, 1);
    req = 2'b00;
    cyc("t3_rel", K_OWN, 1);
    cyc("t3_idle", K_IDLE, 0);

    // simultaneous requests after reset, then hand-over with gap
    do_reset();
    req = 2'b11;
    cyc("t2_c0", K_IDLE, 0);
    cyc("t2_tu0a", K_TURN, 0);
    cyc("t2_tu0b", K_TURN, 0);
    cyc("t2_own0", K_OWN, 0);
    req = 2'b10;
    cyc("t2_rel0", K_OWN, 0);
    cyc("t2_gap", K_IDLE, 0);
    cyc("t2_tu1a", K_TURN, 1);
    cyc("t2_tu1b", K_TURN, 1);
    cyc("t2_own1a", K_OWN, 1);
    cyc("t2_own1b", K_OWN, 1);
    req = 2'b00;
    cyc("t2_rel1", K_OWN, 1);
    cyc("t2_idle", K_IDLE, 0);

    // reset while owned with oe=FF
    req = 2'b01;
    cyc("t4_c0", K_IDLE, 0);
    cyc("t4_tu_a", K_TURN, 0);
    cyc("t4_tu_b", K_TURN, 0);
    cyc("t4_own", K_OWN, 0);
    rst = 1'b1;
    cyc("t4_rst", K_OWN, 0);
    rst = 1'b0;
    req = 2'b00;
    cyc("t4_after", K_IDLE, 0);

    // pull-up and pull-down both requested with outputs disabled
    set_drive(0, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00);
    req = 2'b01;
    cyc("t5_c0", K_IDLE, 0);
    cyc("t5_tu_a", K_TURN, 0);
    cyc("t5_tu_b", K_TURN, 0);
    cyc("t5_own", K_OWN, 0);
    req = 2'b00;
    cyc("t5_rel", K_OWN, 0);
    cyc("t5_idle", K_IDLE, 0);
    set_drive(0, 8'hA5, 8'hFF, 8'h0F, 8'hF0, 8'hF0);

`ifdef PIN_BANK_ARB_TIMEOUT_EN
    do_reset();
    req = 2'b01;
    cyc("t6_c0", K_IDLE, 0);
    cyc("t6_tu_a", K_TURN, 0);
    cyc("t6_tu_b", K_TURN, 0);
    for (int i = 0; i < 4; i++) cyc("t6_own", K_OWN, 0);
    cyc("t6_force", K_IDLE, 0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("t6_masked", K_IDLE, 0);
    req = 2'b00;
    cyc("t6_low", K_IDLE, 0);
    req = 2'b01;
    cyc("t6_rereq", K_IDLE, 0);
    cyc("t6_tu_c", K_TURN, 0);
    cyc("t6_tu_d", K_TURN, 0);
    cyc("t6_own2", K_OWN, 0);
    req = 2'b00;
    cyc("t6_rel", K_OWN, 0);
    cyc("t6_idle", K_IDLE, 0);
`else
    do_reset();
    req = 2'b01;
    cyc("t6_c0", K_IDLE, 0);
    cyc("t6_tu_a", K_TURN, 0);
    cyc("t6_tu_b", K_TURN, 0);
    for (int i = 0; i < 10; i++) cyc("t6_hold", K_OWN, 0);
    req = 2'b00;
    cyc("t6_rel", K_OWN, 0);
    cyc("t6_idle", K_IDLE, 0);
`endif

    @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pin_bank_arbiter.md
PIN_BANK_ARBITER -- requirements
Module: pin_bank_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter Width, default 8, pins in the shared bank.
REQ-003 SHALL have parameter TurnCycles, default 2, bus-turnaround cycles before a grant (1..15).
REQ-004 SHALL have parameter TimeoutCycles, default 64, maximum grant hold; used only when the timeout feature is compiled in.
REQ-005 SHALL have ports: clk_i input 1, sole clock; rst_i input 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: req_i input NumReq, per-requester ownership request, level, held while owning.
REQ-007 SHALL have ports: gnt_o output NumReq, one-hot-or-zero grant.
REQ-008 SHALL have ports: req_o_i, req_oe_i, req_pu_i, req_pd_i inputs NumReq x Width, per-requester drive value, output enable, pull-up and pull-down.
REQ-009 SHALL have ports: pins_o, pins_oe_o, pins_pu_o, pins_pd_o outputs Width, to the pad bank.
REQ-010 SHALL have ports: pins_i input Width, pad readback; sample_o output Width, registered readback.
REQ-011 SHALL have ports: busy_o output 1, state not IDLE; timeout_o output 1, forced-release pulse.

Function
REQ-012 SHALL implement FSM states IDLE, TURN and OWNED.
REQ-013 SHALL, in IDLE with any req_i high, select the owner by round-robin starting at (last owner + 1) mod NumReq, and enter TURN on the next edge.
REQ-014 SHALL hold TURN for exactly TurnCycles cycles via a down-counter, with gnt_o=0, pins_oe_o=0, pins_o=0, and pins_pu_o/pins_pd_o taken from the selected owner's pulls.
REQ-015 SHALL, after TURN, enter OWNED with gnt_o[owner]=1: request at edge t gives the first grant cycle t+1+TurnCycles.
REQ-016 SHALL, in OWNED, pass the owner's o/oe/pu/pd combinationally to pins_*_o.
REQ-017 SHALL, when pu and pd are both set for a bit, drive pins_pd_o=0 for that bit (pull-up wins).
REQ-018 SHALL, in IDLE, drive all pins_*_o to 0 and gnt_o to 0.
REQ-019 SHALL, when req_i[owner] falls in OWNED, go to IDLE on the next edge, with gnt_o and pins_oe_o 0 in that IDLE cycle.
REQ-020 SHALL take at least one IDLE cycle plus TurnCycles between owners, so two requesters never drive in adjacent cycles.
REQ-021 SHALL, when the owner's req drops in TURN, abort to IDLE on the next edge without granting and without updating the last-owner pointer.
REQ-022 SHALL ignore req_i changes of non-owners during TURN and OWNED.
REQ-023 SHALL, when multiple requests arrive simultaneously in IDLE, grant the round-robin winner only, and leave the others pending.
REQ-024 SHALL register sample_o <= pins_i every cycle (1-cycle latency), independent of state.
REQ-025 SHALL set busy_o=1 in TURN and OWNED.

Reset
REQ-026 SHALL, on rst_i high at an edge, enter IDLE regardless of state, including mid-TURN or mid-OWNED.
REQ-027 SHALL, on that reset, clear the turnaround counter, set the last-owner pointer to NumReq-1 (requester 0 first), and clear sample_o, gnt_o, busy_o and timeout_o.
REQ-028 SHALL have all pins_*_o at 0 in the cycle after the reset edge.

Configuration
REQ-029 SHALL compile the grant-timeout feature only when macro PIN_BANK_ARB_TIMEOUT_EN is defined.
REQ-030 SHALL, with PIN_BANK_ARB_TIMEOUT_EN, count OWNED cycles.
REQ-031 SHALL, with PIN_BANK_ARB_TIMEOUT_EN, go to IDLE on the next edge after TimeoutCycles grant cycles.
REQ-032 SHALL, on that forced release, pulse timeout_o for one cycle.
REQ-033 SHALL, after a forced release, mask the offending requester until its req_i is seen low for at least one cycle.
REQ-034 SHALL, without PIN_BANK_ARB_TIMEOUT_EN, have no counter or mask logic, tie timeout_o to 0, and allow a grant to be held indefinitely.

Verification
REQ-035 SHALL cover: defaults, req_i=01 at cycle 0 -> gnt_o=01 from cycle 3; pins_oe_o=0 in cycles 1-2; owner drive visible from cycle 3.
REQ-036 SHALL cover: req_i=11 simultaneously after reset -> requester 0 granted; requester 0 releases -> one IDLE cycle, 2 TURN cycles, then gnt_o=10.
REQ-037 SHALL cover: owner req_i[1] drops during the first TURN cycle -> IDLE next cycle, no grant pulse, next simultaneous request grants requester 1.
REQ-038 SHALL cover: rst_i asserted in OWNED with oe=FF -> pins_oe_o=00, gnt_o=0, busy_o=0 on the following cycle.
REQ-039 SHALL cover: owner drives pu=pd=FF with oe=0 -> pins_pu_o=FF, pins_pd_o=00.
REQ-040 SHALL cover: PIN_BANK_ARB_TIMEOUT_EN, TimeoutCycles=4, req_i[0] held -> gnt_o high 4 cycles, timeout_o pulses once, requester 0 not regranted until req_i[0] toggles low.
